multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle RV32I control unit; replaces the single-cycle opcode decoder for the memory-latency-tolerant NPC core.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with instruction and data memory.
//  Drives datapath strobes: PC, IR, register file, ALU, immediate, result mux.
// PARAMETERS
//  XLEN         32   datapath width; fixes the trap_pc width
//  MEM_TIMEOUT  16   max wait cycles for any memory response before entering S_ERROR (>=2)
//  CNT_W        $clog2(MEM_TIMEOUT+1)  timeout counter width (derived, localparam)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous reset, active low
//  PC           in   XLEN  current PC; captured to trap_pc on error
//  op           in   7     IR[6:0] from the instruction register
//  mem_req      out  1     memory request valid (fetch or data)
//  mem_we       out  1     request is a write (MemWrite)
//  AdrSrc       out  1     0: address=PC (fetch), 1: address=ALU result
//  mem_ready    in   1     memory accepts request this cycle
//  mem_rvalid   in   1     response/write-ack valid
//  IRWrite      out  1     load IR from fetch data
//  PCWrite      out  1     update PC (next PC selected by PCSrc)
//  PCSrc        out  2     00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//  Branch       out  1     PC+imm taken if ALU Zero
//  RegWrite     out  1     write rd
//  ALUSrc       out  1     1: rs1 op imm, 0: rs1 op rs2
//  ImmSrc       out  3     000 I, 001 S, 010 B, 011 J, 100 U
//  ALUOp        out  2     00 add, 01 sub, 10 by funct3
//  ResultSrc    out  3     000 ALU, 001 mem, 010 PC+4, 011 PC+imm, 100 imm
//  Ret          out  1     jalr executing (return-trace strobe)
//  busy         out  1     high in every state except S_FETCH with no request pending
//  bus_err      out  1     sticky: memory timeout
//  trap_pc      out  XLEN  PC of the faulting instruction; 0 out of reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_FETCH, timeout counter=0, bus_err=0, trap_pc=0; all strobes 0 while rst_n=0.
//  Strobes are Moore outputs of the state register; IRWrite/PCWrite/RegWrite are one-cycle pulses.
//  S_FETCH: mem_req=1, AdrSrc=0; holds until mem_ready -> S_IFWAIT.
//  S_IFWAIT: wait for mem_rvalid; on it IRWrite=1 -> S_DECODE.
//  S_DECODE: ImmSrc per op; lw/sw->S_MEMADR, R/I-ALU->S_EXEC, beq->S_BRANCH, jal->S_JAL, jalr->S_JALR, auipc/lui->S_UWB.
//  S_EXEC -> S_ALUWB (RegWrite=1, ResultSrc=000, PCWrite=1, PCSrc=00) -> S_FETCH.
//  S_MEMADR: ALUSrc=1, ALUOp=00; mem_req=1, AdrSrc=1, mem_we=(op==sw); waits for mem_ready -> S_MEMWAIT.
//  S_MEMWAIT: on mem_rvalid: lw -> S_MEMWB (RegWrite, ResultSrc=001, PCWrite); sw -> PCWrite=1 -> S_FETCH.
//  S_BRANCH: ALUOp=01, Branch=1, PCWrite=1 -> S_FETCH. S_JAL: RegWrite, ResultSrc=010, PCSrc=01, PCWrite -> S_FETCH.
//  S_JALR: as S_JAL but PCSrc=10, Ret=1. S_UWB: RegWrite, ResultSrc=011 (auipc)/100 (lui), PCWrite -> S_FETCH.
//  Cycles/instr at zero-wait memory (mem_ready, then mem_rvalid next cycle): ALU 5, branch/jal/U 4, lw 6, sw 5.
//  Timeout: counter clears on entry to S_FETCH/S_IFWAIT/S_MEMADR/S_MEMWAIT, increments each waiting cycle there;
//   reaching MEM_TIMEOUT -> S_ERROR, bus_err=1, trap_pc=PC. S_ERROR absorbs: no strobes; exit only via reset.
//  mem_ready and mem_rvalid in the same cycle: accepted as ready; rvalid ignored unless in a WAIT state.
//  mem_rvalid outside a WAIT state: ignored. Reset mid-instruction aborts without any write strobe.
// CONFIGURATION
//  MCTRL_ILLEGAL_TRAP_EN defined: unknown opcode in S_DECODE -> S_ERROR, illegal output (1 bit, sticky) =1, trap_pc=PC.
//  Not defined: unknown opcode executes as NOP (PCWrite, PCSrc=00 -> S_FETCH); illegal port absent.
// STRUCTURE
//  mctrl_pkg: state enum (S_FETCH..S_ERROR), opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL,
//   OP_JALR, OP_AUIPC, OP_LUI), ImmSrc/ResultSrc/ALUOp/PCSrc encodings.
//  Sub-module mctrl_opdec: combinational op -> instruction class + ImmSrc + legal flag; FSM in this module.
// TESTING
//  add (op=0110011), zero-wait mem -> RegWrite pulse in cycle 5, ResultSrc=000, ALUOp=10, PCWrite same cycle.
//  lw, mem_rvalid delayed 3 cycles in S_MEMWAIT -> RegWrite with ResultSrc=001 exactly 1 cycle after rvalid.
//  sw -> mem_req=1, mem_we=1, AdrSrc=1 until mem_ready; RegWrite never asserted.
//  Fetch with mem_ready held 0 for 16 cycles -> bus_err=1, trap_pc=PC, no further strobes until rst_n.
//  op=0000000 with MCTRL_ILLEGAL_TRAP_EN -> illegal=1, S_ERROR; without -> PC+4 and next fetch.
//  rst_n low during S_MEMWAIT of lw -> outputs 0 immediately; after release, mem_req=1 with AdrSrc=0.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// RV32I major opcodes, instruction classes and datapath select encodings.
package mctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_IFWAIT, S_DECODE, S_MEMADR, S_MEMWAIT, S_MEMWB,
        S_EXEC, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UWB, S_ERROR
    } state_e;

    typedef enum logic [3:0] {
        CL_LOAD, CL_STORE, CL_ALU_R, CL_ALU_I, CL_BRANCH,
        CL_JAL, CL_JALR, CL_AUIPC, CL_LUI, CL_ILLEGAL
    } iclass_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] RES_ALU   = 3'b000;
    localparam logic [2:0] RES_MEM   = 3'b001;
    localparam logic [2:0] RES_PC4   = 3'b010;
    localparam logic [2:0] RES_PCIMM = 3'b011;
    localparam logic [2:0] RES_IMM   = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_F3  = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

endpackage

// File: rtl/mctrl_opdec.sv
// Opcode decoder: maps IR[6:0] to an instruction class, the immediate
// format for the immediate generator, and a legal-opcode flag.
module mctrl_opdec
    import mctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [3:0] cls_o,
    output logic [2:0] imm_src_o,
    output logic       legal_o
);

    // Pure lookup; unknown opcodes fall out as CL_ILLEGAL with legal_o low.
    always_comb begin
        cls_o     = CL_ILLEGAL;
        imm_src_o = IMM_I;
        legal_o   = 1'b1;
        case (op_i)
            OP_LOAD:  cls_o = CL_LOAD;
            OP_STORE: begin cls_o = CL_STORE;  imm_src_o = IMM_S; end
            OP_R:     cls_o = CL_ALU_R;
            OP_I:     cls_o = CL_ALU_I;
            OP_BR:    begin cls_o = CL_BRANCH; imm_src_o = IMM_B; end
            OP_JAL:   begin cls_o = CL_JAL;    imm_src_o = IMM_J; end
            OP_JALR:  cls_o = CL_JALR;
            OP_AUIPC: begin cls_o = CL_AUIPC;  imm_src_o = IMM_U; end
            OP_LUI:   begin cls_o = CL_LUI;    imm_src_o = IMM_U; end
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB with a
// ready/rvalid memory handshake and a per-wait timeout that traps to S_ERROR.
// Optional build macro MCTRL_ILLEGAL_TRAP_EN: unknown opcodes trap to S_ERROR
// and raise the sticky 'illegal' output; otherwise they retire as a NOP.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC,
    input  logic [6:0]      op,
    output logic            mem_req,
    output logic            mem_we,
    output logic            AdrSrc,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic [1:0]      PCSrc,
    output logic            Branch,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic [2:0]      ImmSrc,
    output logic [1:0]      ALUOp,
    output logic [2:0]      ResultSrc,
    output logic            Ret,
    output logic            busy,
    output logic            bus_err,
    output logic [XLEN-1:0] trap_pc
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic            illegal_q, illegal_d;
`endif
    logic            wait_tick;
    logic [3:0]      cls;
    logic [2:0]      imm_src;
    logic            legal;

    mctrl_opdec u_opdec (
        .op_i      (op),
        .cls_o     (cls),
        .imm_src_o (imm_src),
        .legal_o   (legal)
    );

    // Next-state, timeout counter and trap capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        trap_pc_d = trap_pc_q;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        wait_tick = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready)  state_d = S_IFWAIT; else wait_tick = 1'b1;
            S_IFWAIT:  if (mem_rvalid) state_d = S_DECODE; else wait_tick = 1'b1;
            S_DECODE: begin
                if (!legal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    state_d   = S_ERROR;
                    illegal_d = 1'b1;
                    trap_pc_d = PC;
`else
                    state_d   = S_FETCH;
`endif
                end else begin
                    case (cls)
                        CL_LOAD, CL_STORE:  state_d = S_MEMADR;
                        CL_ALU_R, CL_ALU_I: state_d = S_EXEC;
                        CL_BRANCH:          state_d = S_BRANCH;
                        CL_JAL:             state_d = S_JAL;
                        CL_JALR:            state_d = S_JALR;
                        default:            state_d = S_UWB;
                    endcase
                end
            end
            S_MEMADR:  if (mem_ready) state_d = S_MEMWAIT; else wait_tick = 1'b1;
            S_MEMWAIT: begin
                if (mem_rvalid) state_d = (cls == CL_LOAD) ? S_MEMWB : S_FETCH;
                else            wait_tick = 1'b1;
            end
            S_EXEC:    state_d = S_ALUWB;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_FETCH;
        endcase
        if (wait_tick) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = S_ERROR;
                bus_err_d = 1'b1;
                trap_pc_d = PC;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Every state change restarts the wait budget for the state entered.
        if (state_d != state_q) cnt_d = '0;
    end

    // State and sticky trap registers; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            trap_pc_q <= '0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            trap_pc_q <= trap_pc_d;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Moore strobes from the state register, forced low while reset is held.
    // IRWrite and the store PCWrite also qualify on the rvalid they consume.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = PC_PLUS4;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        ImmSrc    = IMM_I;
        ALUOp     = ALU_ADD;
        ResultSrc = RES_ALU;
        Ret       = 1'b0;
        busy      = 1'b0;
        if (rst_n) begin
            busy = (state_q != S_FETCH);
            case (state_q)
                S_FETCH:   mem_req = 1'b1;
                S_IFWAIT:  IRWrite = mem_rvalid;
                S_DECODE: begin
                    ImmSrc = imm_src;
`ifndef MCTRL_ILLEGAL_TRAP_EN
                    PCWrite = !legal;
`endif
                end
                S_MEMADR: begin
                    ImmSrc  = imm_src;
                    ALUSrc  = 1'b1;
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    mem_we  = (cls == CL_STORE);
                end
                S_MEMWAIT: begin
                    ImmSrc  = imm_src;
                    AdrSrc  = 1'b1;
                    PCWrite = mem_rvalid && (cls == CL_STORE);
                end
                S_MEMWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_MEM;
                    PCWrite   = 1'b1;
                end
                S_EXEC, S_ALUWB: begin
                    ImmSrc   = imm_src;
                    ALUSrc   = (cls == CL_ALU_I);
                    ALUOp    = ALU_F3;
                    RegWrite = (state_q == S_ALUWB);
                    PCWrite  = (state_q == S_ALUWB);
                end
                S_BRANCH: begin
                    ImmSrc  = imm_src;
                    ALUOp   = ALU_SUB;
                    Branch  = 1'b1;
                    PCWrite = 1'b1;
                end
                S_JAL, S_JALR: begin
                    ImmSrc    = imm_src;
                    ALUSrc    = 1'b1;
                    RegWrite  = 1'b1;
                    ResultSrc = RES_PC4;
                    PCWrite   = 1'b1;
                    PCSrc     = (state_q == S_JALR) ? PC_REG : PC_IMM;
                    Ret       = (state_q == S_JALR);
                end
                S_UWB: begin
                    ImmSrc    = imm_src;
                    RegWrite  = 1'b1;
                    ResultSrc = (cls == CL_LUI) ? RES_IMM : RES_PCIMM;
                    PCWrite   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_err = bus_err_q;
    assign trap_pc = trap_pc_q;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction task queues the
// write-strobe events it expects (cycle + strobe vector); a monitor pops and
// compares whenever IRWrite, PCWrite or RegWrite is seen.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC = 32'h0000_1000;
    logic [6:0]  op = 7'd0;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic        mem_req, mem_we, AdrSrc, IRWrite, PCWrite, Branch, RegWrite;
    logic        ALUSrc, Ret, busy, bus_err;
    logic [1:0]  PCSrc, ALUOp;
    logic [2:0]  ImmSrc, ResultSrc;
    logic [31:0] trap_pc;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .op(op),
        .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp),
        .ResultSrc(ResultSrc), .Ret(Ret), .busy(busy), .bus_err(bus_err),
        .trap_pc(trap_pc)
`ifdef MCTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // {IRWrite, PCWrite, RegWrite, ResultSrc[2:0], PCSrc[1:0], ALUOp[1:0], Ret, Branch}
    logic [11:0] strobe_vec;
    assign strobe_vec = {IRWrite, PCWrite, RegWrite, ResultSrc, PCSrc, ALUOp, Ret, Branch};

    localparam logic [11:0] FULL    = 12'hFFF;
    localparam logic [11:0] NO_PCS  = 12'hFCF;
    localparam logic [11:0] EV_IRW  = 12'b1_0_0_000_00_00_0_0;
    localparam logic [11:0] EV_ALU  = 12'b0_1_1_000_00_10_0_0;
    localparam logic [11:0] EV_LUI  = 12'b0_1_1_100_00_00_0_0;
    localparam logic [11:0] EV_AUI  = 12'b0_1_1_011_00_00_0_0;
    localparam logic [11:0] EV_JAL  = 12'b0_1_1_010_01_00_0_0;
    localparam logic [11:0] EV_JALR = 12'b0_1_1_010_10_00_1_0;
    localparam logic [11:0] EV_BR   = 12'b0_1_0_000_00_01_0_1;
    localparam logic [11:0] EV_LW   = 12'b0_1_1_001_00_00_0_0;
    localparam logic [11:0] EV_PC4  = 12'b0_1_0_000_00_00_0_0;

    typedef struct {
        string       name;
        int          cyc;
        logic [11:0] vec;
        logic [11:0] msk;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input string name, input int c, input logic [11:0] v,
                             input logic [11:0] m);
        exp_t x;
        x.name = name;
        x.cyc  = c;
        x.vec  = v;
        x.msk  = m;
        sbq.push_back(x);
    endtask

    // Monitor: any write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (IRWrite || PCWrite || RegWrite) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got %03h at cycle %0d, expected none",
                         strobe_vec, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (cyc != mon_e.cyc || ((strobe_vec ^ mon_e.vec) & mon_e.msk) != 12'd0) begin
                    n_fail++;
                    $display("FAIL %s: got %03h at cycle %0d, expected %03h at cycle %0d",
                             mon_e.name, strobe_vec, cyc, mon_e.vec, mon_e.cyc);
                end
            end
        end
    end

    // Instruction fetch: rw cycles without ready, ready (optionally with a
    // stray rvalid), vw idle cycles, then the fetch response. Returns at DECODE.
    task automatic fetch(input int rw, input int vw, input bit both, input logic [6:0] opc);
        for (int i = 0; i < rw; i++) begin
            #1 check("fetch_req", 32'({mem_req, AdrSrc, mem_we}), 32'b100);
            @(negedge clk);
        end
        mem_ready  = 1'b1;
        mem_rvalid = both;
        #1 check("fetch_req", 32'({mem_req, AdrSrc, mem_we}), 32'b100);
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i < vw; i++) @(negedge clk);
        mem_rvalid = 1'b1;
        op         = opc;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    // Data access from S_MEMADR; returns on the cycle after the response.
    task automatic data_phase(input int rw, input int vw, input logic we);
        for (int i = 0; i < rw; i++) begin
            #1 check("data_req", 32'({mem_req, AdrSrc, mem_we}), 32'({2'b11, we}));
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1 check("data_req", 32'({mem_req, AdrSrc, mem_we}), 32'({2'b11, we}));
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < vw; i++) @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic do_instr(input string name, input logic [6:0] opc, input logic [2:0] imm_exp,
                            input int rw, input int vw, input bit both,
                            input int drw, input int dvw);
        int base, d, rv;
        base = cyc;
        d    = base + rw + vw + 2;
        rv   = d + 2 + drw + dvw;
        expect_ev({name, "_irwrite"}, d - 1, EV_IRW, FULL);
        case (opc)
            7'b0110011, 7'b0010011: expect_ev({name, "_wb"}, d + 2, EV_ALU, FULL);
            7'b0110111: expect_ev({name, "_wb"}, d + 1, EV_LUI, FULL);
            7'b0010111: expect_ev({name, "_wb"}, d + 1, EV_AUI, FULL);
            7'b1101111: expect_ev({name, "_wb"}, d + 1, EV_JAL, FULL);
            7'b1100111: expect_ev({name, "_wb"}, d + 1, EV_JALR, FULL);
            7'b1100011: expect_ev({name, "_pc"}, d + 1, EV_BR, NO_PCS);
            7'b0000011: expect_ev({name, "_wb"}, rv + 1, EV_LW, FULL);
            7'b0100011: expect_ev({name, "_pc"}, rv, EV_PC4, FULL);
            default: begin
`ifndef MCTRL_ILLEGAL_TRAP_EN
                expect_ev({name, "_nop_pc"}, d, EV_PC4, FULL);
`endif
            end
        endcase
        fetch(rw, vw, both, opc);
        #1 check({name, "_immsrc"}, 32'(ImmSrc), 32'(imm_exp));
        case (opc)
            7'b0110011, 7'b0010011: repeat (3) @(negedge clk);
            7'b0000011, 7'b0100011: begin
                @(negedge clk);
                data_phase(drw, dvw, opc[5]);
                if (opc == 7'b0000011) @(negedge clk);
            end
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011:
                repeat (2) @(negedge clk);
            default: @(negedge clk);
        endcase
        #1 check({name, "_next_fetch"}, 32'({mem_req, AdrSrc, busy}), 32'b100);
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check({name, "_outputs_low"},
                 32'({mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, busy, Branch, Ret}),
                 32'd0);
        check({name, "_trap_clear"}, 32'({bus_err, trap_pc != 32'd0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check({name, "_fetch_after"}, 32'({mem_req, AdrSrc, busy}), 32'b100);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 check("reset_outputs",
                 32'({mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, busy, Ret, Branch}),
                 32'd0);
        check("reset_bus_err", 32'(bus_err), 32'd0);
        check("reset_trap_pc", trap_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_fetch", 32'({mem_req, AdrSrc, busy}), 32'b100);

        do_instr("add",   7'b0110011, 3'b000, 0, 0, 0, 0, 0);
        do_instr("addi",  7'b0010011, 3'b000, 2, 1, 1, 0, 0);
        do_instr("lui",   7'b0110111, 3'b100, 0, 0, 0, 0, 0);
        do_instr("auipc", 7'b0010111, 3'b100, 1, 0, 0, 0, 0);
        do_instr("jal",   7'b1101111, 3'b011, 0, 0, 0, 0, 0);
        do_instr("jalr",  7'b1100111, 3'b000, 0, 0, 0, 0, 0);
        do_instr("beq",   7'b1100011, 3'b010, 0, 0, 0, 0, 0);
        do_instr("lw",    7'b0000011, 3'b000, 0, 0, 0, 0, 3);
        do_instr("sw",    7'b0100011, 3'b001, 0, 0, 0, 2, 0);

`ifdef MCTRL_ILLEGAL_TRAP_EN
        PC = 32'h0000_0200;
        expect_ev("illegal_irwrite", cyc + 1, EV_IRW, FULL);
        fetch(0, 0, 0, 7'b0000000);
        @(negedge clk);
        #1 check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_trap_pc", trap_pc, 32'h0000_0200);
        check("illegal_no_req", 32'({mem_req, bus_err}), 32'd0);
        PC = 32'h0000_1000;
`else
        do_instr("nop", 7'b0000000, 3'b000, 0, 0, 0, 0, 0);
`endif
        reset_pulse("rst1");

        // Reset while a load waits in S_MEMWAIT: no write strobe may follow.
        expect_ev("abort_irwrite", cyc + 1, EV_IRW, FULL);
        fetch(0, 0, 0, 7'b0000011);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1 check("abort_busy_memwait", 32'(busy), 32'd1);
        reset_pulse("abort");

        // Fetch timeout: 16 waiting cycles then S_ERROR.
        PC = 32'h0000_0ABC;
        repeat (15) @(negedge clk);
        #1 check("timeout_boundary", 32'({bus_err, mem_req}), 32'b01);
        @(negedge clk);
        #1 check("timeout_bus_err", 32'(bus_err), 32'd1);
        check("timeout_trap_pc", trap_pc, 32'h0000_0ABC);
        check("error_no_req", 32'({mem_req, busy}), 32'b01);
        PC = 32'h0000_1234;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        repeat (4) @(negedge clk);
        #1 check("error_absorbs", 32'({mem_req, bus_err}), 32'b01);
        check("error_trap_hold", trap_pc, 32'h0000_0ABC);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        PC = 32'h0000_1000;
        reset_pulse("rst2");

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
